// File: rtl/rc5_tx.sv
// RC5 infrared transmitter with a CSR page (DATA/CTRL registers).
// Sends a start bit plus 13 data bits Manchester coded, with optional 36 kHz carrier.
module rc5_tx #(
  parameter logic [3:0]  csr_addr = 4'h0,
  parameter int unsigned clk_freq = 100000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        tx_irq,
  output logic        tx
);

  localparam int unsigned HB   = clk_freq / 1125;
  localparam int unsigned CT   = clk_freq / 72000;
  localparam int unsigned HB_W = (HB > 1) ? $clog2(HB) : 1;
  localparam int unsigned CT_W = (CT > 1) ? $clog2(CT) : 1;
  localparam logic [HB_W-1:0] HB_RELOAD = HB_W'(HB - 1);
  localparam logic [CT_W-1:0] CT_RELOAD = CT_W'(CT - 1);
  localparam logic [4:0]      LAST_HALF = 5'd27;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t          state_q;
  logic [HB_W-1:0] hb_cnt_q;
  logic [CT_W-1:0] ct_cnt_q;
  logic            carrier_q;
  logic            carrier_en_q;
  logic [4:0]      half_q;
  logic [13:0]     frame_q;
  logic            tx_q;
  logic            irq_q;
  logic [31:0]     csr_do_q;

  logic        page_sel;
  logic        wr_data;
  logic        wr_ctrl;
  logic        accept;
  logic        hb_tick;
  logic        cur_bit;
  logic        mark;
  logic        tx_d;
  logic [31:0] csr_do_d;
  logic        unused_bits;

  assign unused_bits = ^{csr_di[31:13], csr_a[9:1]};

  assign page_sel = (csr_a[13:10] == csr_addr);
  assign wr_data  = page_sel & csr_we & ~csr_a[0];
  assign wr_ctrl  = page_sel & csr_we & csr_a[0];
  // The completion-pulse cycle is still treated as busy so a write there is dropped.
  assign accept   = wr_data & (state_q == IDLE) & ~irq_q;
  assign hb_tick  = (hb_cnt_q == '0);

  // Even half-bits carry the inverted bit, odd half-bits the bit itself.
  assign cur_bit = frame_q[4'd13 - half_q[4:1]];
  assign mark    = (state_q == SEND) & ~(cur_bit ^ half_q[0]);
  assign tx_d    = mark & (carrier_en_q ? carrier_q : 1'b1);

  always_comb begin
    csr_do_d = '0;
    if (page_sel) begin
      if (csr_a[0]) begin
        csr_do_d = {30'd0, carrier_en_q, (state_q == SEND)};
      end else begin
        csr_do_d = {19'd0, frame_q[12:0]};
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      hb_cnt_q     <= HB_RELOAD;
      ct_cnt_q     <= CT_RELOAD;
      carrier_q    <= 1'b0;
      carrier_en_q <= 1'b0;
      half_q       <= '0;
      frame_q      <= '0;
      tx_q         <= 1'b0;
      irq_q        <= 1'b0;
      csr_do_q     <= '0;
    end else begin
      if (ct_cnt_q == '0) begin
        ct_cnt_q  <= CT_RELOAD;
        carrier_q <= ~carrier_q;
      end else begin
        ct_cnt_q <= ct_cnt_q - CT_W'(1);
      end

      if (wr_ctrl) begin
        carrier_en_q <= csr_di[1];
      end

      tx_q     <= tx_d;
      irq_q    <= 1'b0;
      csr_do_q <= csr_do_d;

      case (state_q)
        IDLE: begin
          if (accept) begin
            frame_q  <= {1'b1, csr_di[12:0]};
            hb_cnt_q <= HB_RELOAD;
            half_q   <= '0;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (hb_tick) begin
            hb_cnt_q <= HB_RELOAD;
            if (half_q == LAST_HALF) begin
              half_q  <= '0;
              irq_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              half_q <= half_q + 5'd1;
            end
          end else begin
            hb_cnt_q <= hb_cnt_q - HB_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx     = tx_q;
  assign tx_irq = irq_q;
  assign csr_do = csr_do_q;

endmodule
